// File: rtl/fft_pkg.sv
// fft_pkg: constants and types shared by the 8-point FFT core and its
// input framer.
//   FFT_N             points per frame
//   Q39_*             input sample format (signed Q3.9, 12 bits)
//   Q57_*             core output format (signed Q5.7, 12 bits)
//   FFT_CORE_LATENCY  clock edges from an x change to the matching y
package fft_pkg;

  localparam int FFT_N            = 8;

  localparam int Q39_W            = 12;
  localparam int Q39_INT          = 3;
  localparam int Q39_FRAC         = Q39_W - Q39_INT;

  localparam int Q57_W            = 12;
  localparam int Q57_INT          = 5;
  localparam int Q57_FRAC         = Q57_W - Q57_INT;

  // Input register plus three butterfly stages.
  localparam int FFT_CORE_LATENCY = 4;

  typedef struct packed {
    logic signed [Q39_W-1:0] re;
    logic signed [Q39_W-1:0] im;
  } cplx_q39_t;

  typedef struct packed {
    logic signed [Q57_W-1:0] re;
    logic signed [Q57_W-1:0] im;
  } cplx_q57_t;

endpackage

// File: rtl/fft_valid_delay.sv
// fft_valid_delay: fixed-length pulse delay line.
//   clk   clock, posedge
//   rst   synchronous active-high clear of every stage
//   din   pulse in
//   dout  din delayed by DEPTH clock edges
module fft_valid_delay
  import fft_pkg::*;
#(
  parameter int DEPTH = FFT_CORE_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  // vld_pipe[i] holds din as it was i+1 edges ago.
  logic [DEPTH-1:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
      end
    end
  end

  assign dout = vld_pipe[DEPTH-1];

endmodule

// File: rtl/fft_input_framer.sv
// fft_input_framer: collects N complex samples per frame into a two-bank
// ping-pong buffer and presents each complete frame, held stable, on the
// FFT core's parallel x inputs. y_valid marks the cycle the core's outputs
// hold the result of that frame.
//   clk, rst          clock; synchronous active-high reset
//   s_valid/s_ready   sample handshake; s_ready is registered-state only
//   s_real/s_imag     Q3.9 sample, passed through bit-exact
//   s_last            marks the Nth sample of a frame
//   frame_ready       downstream can take a new frame
//   x_real_flat/_imag x0..x(N-1), x0 in the LSBs
//   frame_strobe      new frame on x_* this cycle
//   y_valid           core outputs hold that frame's FFT this cycle
//   frame_err         s_last protocol violation (one-cycle pulse)
module fft_input_framer
  import fft_pkg::*;
#(
  parameter int N                = FFT_N,
  parameter int INPUT_WORD_WIDTH = Q39_W,
  parameter int FFT_LATENCY      = FFT_CORE_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [INPUT_WORD_WIDTH-1:0]   s_real,
  input  logic [INPUT_WORD_WIDTH-1:0]   s_imag,
  input  logic                          s_last,
  input  logic                          frame_ready,
  output logic [N*INPUT_WORD_WIDTH-1:0] x_real_flat,
  output logic [N*INPUT_WORD_WIDTH-1:0] x_imag_flat,
  output logic                          frame_strobe,
  output logic                          y_valid,
  output logic                          frame_err
);

  localparam int NUM_LANES = N;
  localparam int VEC_W     = INPUT_WORD_WIDTH;
  localparam int IDX_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

  typedef struct packed {
    logic [VEC_W-1:0] re;
    logic [VEC_W-1:0] im;
  } samp_t;

  // Two frame banks; wptr fills one while rptr drains the other.
  samp_t [1:0][NUM_LANES-1:0] bank;

  logic [IDX_W-1:0] widx;
  logic             wptr, rptr;
  logic [1:0]       full, full_nxt;
  // A completed bank is flagged full one edge after its last sample, so
  // the issue point lands two edges after the final handshake. The frame
  // is counted as occupying its bank from the handshake onward.
  logic             commit_pend;
  logic             commit_bank;
  logic [1:0]       occ;

  logic             accept, last_slot, commit, drain;

  logic [NUM_LANES-1:0][VEC_W-1:0] rd_re, rd_im;
  logic [NUM_LANES-1:0][VEC_W-1:0] x_re_q, x_im_q;

  // ---------------------------------------------------------------
  // Handshake and bookkeeping
  // ---------------------------------------------------------------
  assign occ       = {1'b0, full[0]} + {1'b0, full[1]} + {1'b0, commit_pend};
  assign s_ready   = (occ < 2'd2);
  assign accept    = s_valid & s_ready;
  assign last_slot = (widx == LAST_IDX);
  assign commit    = accept & last_slot;
  assign drain     = full[rptr] & frame_ready;

  // Drain and commit never target the same bank: a pending commit's bank
  // is not yet full, so it cannot be the one being drained.
  always_comb begin
    full_nxt = full;
    if (drain)       full_nxt[rptr]        = 1'b0;
    if (commit_pend) full_nxt[commit_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      widx         <= '0;
      wptr         <= 1'b0;
      rptr         <= 1'b0;
      full         <= '0;
      commit_pend  <= 1'b0;
      commit_bank  <= 1'b0;
      frame_strobe <= 1'b0;
      frame_err    <= 1'b0;
      x_re_q       <= '0;
      x_im_q       <= '0;
    end else begin
      full         <= full_nxt;
      commit_pend  <= commit;
      frame_strobe <= drain;
      // Error when s_last disagrees with the slot: missing on the last
      // slot, or early on any other.
      frame_err    <= accept & (last_slot ^ s_last);

      if (commit) commit_bank <= wptr;

      if (accept) begin
        if (last_slot) begin
          widx <= '0;
          wptr <= ~wptr;
        end else if (s_last) begin
          // Early s_last: drop the partial frame, reuse the same bank.
          widx <= '0;
        end else begin
          widx <= widx + 1'b1;
        end
      end

      if (drain) begin
        rptr   <= ~rptr;
        x_re_q <= rd_re;
        x_im_q <= rd_im;
      end
    end
  end

  // ---------------------------------------------------------------
  // Sample storage (data only, no reset needed)
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) bank[wptr][widx] <= {s_real, s_imag};
  end

  // Per-lane read gather from the bank being drained.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign rd_re[k] = bank[rptr][k].re;
    assign rd_im[k] = bank[rptr][k].im;
  end

  assign x_real_flat = x_re_q;
  assign x_imag_flat = x_im_q;

  // ---------------------------------------------------------------
  // Output-valid alignment with the core pipeline
  // ---------------------------------------------------------------
  fft_valid_delay #(
    .DEPTH (FFT_LATENCY)
  ) u_valid_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (frame_strobe),
    .dout (y_valid)
  );

endmodule

// File: tb/tb_fft_input_framer.sv
// tb_fft_input_framer: randomized and directed stimulus with a
// frame-level reference model. Expected frames are queued when the model
// decides a frame is issued; a negedge monitor pops and compares.
module tb_fft_input_framer;
  import fft_pkg::*;

  localparam int N   = FFT_N;
  localparam int W   = Q39_W;
  localparam int LAT = FFT_CORE_LATENCY;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_valid, s_ready, s_last, frame_ready;
  logic [W-1:0]   s_real, s_imag;
  logic [N*W-1:0] x_real_flat, x_imag_flat;
  logic           frame_strobe, y_valid, frame_err;

  fft_input_framer dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_real       (s_real),
    .s_imag       (s_imag),
    .s_last       (s_last),
    .frame_ready  (frame_ready),
    .x_real_flat  (x_real_flat),
    .x_imag_flat  (x_imag_flat),
    .frame_strobe (frame_strobe),
    .y_valid      (y_valid),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] re;
    logic [N*W-1:0] im;
    int             elig;   // first edge at which the frame may issue
  } frame_t;

  // Reference model state
  frame_t         pend_q[$];   // complete frames awaiting issue (<= 2)
  frame_t         exp_q[$];    // issued frames awaiting frame_strobe
  int             yq[$];       // issue edges awaiting y_valid
  logic [W-1:0]   part_re[$], part_im[$];
  logic [N*W-1:0] held_re = '0, held_im = '0;
  bit             strobe_due, y_due, err_due;
  int             ecnt = 0;
  frame_t         nf, ef;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt = 0;
  bit rnd_done;

  task automatic chk(input string name, input logic [N*W-1:0] act,
                     input logic [N*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: frames are issued in order, one per edge, no earlier than two
  // edges after their last sample and only while frame_ready is high;
  // y_valid follows an issue by LAT edges; s_last mismatches flag errors.
  always @(posedge clk) begin
    ecnt++;
    strobe_due = 1'b0;
    y_due      = 1'b0;
    err_due    = 1'b0;
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
      yq.delete();
      part_re.delete();
      part_im.delete();
      held_re = '0;
      held_im = '0;
    end else begin
      if (frame_ready && pend_q.size() > 0 && pend_q[0].elig <= ecnt) begin
        nf = pend_q.pop_front();
        held_re = nf.re;
        held_im = nf.im;
        exp_q.push_back(nf);
        yq.push_back(ecnt);
        strobe_due = 1'b1;
      end
      if (yq.size() > 0 && yq[0] + LAT == ecnt) begin
        void'(yq.pop_front());
        y_due = 1'b1;
      end
      if (s_valid && s_ready) begin
        part_re.push_back(s_real);
        part_im.push_back(s_imag);
        if (part_re.size() == N) begin
          for (int k = 0; k < N; k++) begin
            nf.re[k*W +: W] = part_re[k];
            nf.im[k*W +: W] = part_im[k];
          end
          nf.elig = ecnt + 2;
          pend_q.push_back(nf);
          err_due = !s_last;
          part_re.delete();
          part_im.delete();
        end else if (s_last) begin
          part_re.delete();
          part_im.delete();
          err_due = 1'b1;
        end
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    chk("frame_strobe", N*W'(frame_strobe), N*W'(strobe_due));
    if (frame_strobe) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame: strobe with no expected frame (t=%0t)", $time);
      end else begin
        ef = exp_q.pop_front();
        chk("frame_real", x_real_flat, ef.re);
        chk("frame_imag", x_imag_flat, ef.im);
      end
    end
    chk("y_valid",   N*W'(y_valid),   N*W'(y_due));
    chk("frame_err", N*W'(frame_err), N*W'(err_due));
    chk("s_ready",   N*W'(s_ready),   N*W'(pend_q.size() < 2));
    chk("x_real_hold", x_real_flat, held_re);
    chk("x_imag_hold", x_imag_flat, held_im);
  end

  task automatic send(input logic [W-1:0] re, input logic [W-1:0] im,
                      input logic last);
    int waitc = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_real  = re;
    s_imag  = im;
    s_last  = last;
    while (!s_ready) begin
      waitc++;
      stall_cnt++;
      if (waitc > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: s_ready low for %0d cycles, required 1", waitc);
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic ramp_frame();
    frame_ready = 1'b1;
    for (int k = 0; k < N; k++) send(W'(k * 256), '0, k == N - 1);
    idle(8);
    begin
      int sum = 0;
      for (int k = 0; k < N; k++) sum += int'(x_real_flat[k*W +: W]);
      chk("ramp_dc_sum", N*W'(sum), N*W'(28 * 256));
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; frame_ready = 1'b0;
    s_real = '0; s_imag = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_x_real", x_real_flat, '0);
    chk("reset_s_ready", N*W'(s_ready), N*W'(1));

    // Ramp frame
    ramp_frame();

    // Three frames with the consumer stalled: the 17th sample waits
    frame_ready = 1'b0;
    stall_cnt   = 0;
    fork
      for (int i = 0; i < 3 * N; i++)
        send(W'($urandom), W'($urandom), (i % N) == N - 1);
      begin
        repeat (40) @(negedge clk);
        frame_ready = 1'b1;
      end
    join
    idle(12);
    chk("stall_seen", N*W'(stall_cnt > 0), N*W'(1));

    // Early s_last on the 5th sample, then a clean frame 100..107
    frame_ready = 1'b1;
    for (int k = 0; k < 5; k++) send(W'(k + 1), '0, k == 4);
    for (int k = 0; k < N; k++) send(W'(100 + k), W'(k), k == N - 1);
    idle(4);
    chk("early_last_x0", N*W'(x_real_flat[W-1:0]), N*W'(100));

    // Missing s_last on the 8th sample: frame still issued
    for (int k = 0; k < N; k++) send(W'(200 + k), W'(-k), 1'b0);
    idle(4);
    chk("no_last_x7", N*W'(x_real_flat[(N-1)*W +: W]), N*W'(207));

    // Continuous stream, four frames
    stall_cnt = 0;
    for (int i = 0; i < 4 * N; i++)
      send(W'($urandom), W'($urandom), (i % N) == N - 1);
    idle(10);
    chk("stream_no_stall", N*W'(stall_cnt), '0);

    // Reset two cycles after a strobe with one bank still full
    frame_ready = 1'b0;
    for (int i = 0; i < 2 * N; i++)
      send(W'($urandom), W'($urandom), (i % N) == N - 1);
    idle(3);
    @(negedge clk); frame_ready = 1'b1;
    @(negedge clk); frame_ready = 1'b0;
    @(negedge clk);
    do_reset();
    chk("rst_x_real", x_real_flat, '0);
    chk("rst_x_imag", x_imag_flat, '0);
    chk("rst_strobe", N*W'(frame_strobe), '0);
    frame_ready = 1'b1;
    idle(10);
    ramp_frame();

    // Random traffic with backpressure and occasional s_last errors
    rnd_done = 1'b0;
    fork
      begin
        int pos = 0;
        logic last;
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          pos++;
          last = (pos == N);
          if ($urandom_range(0, 9) == 0) last = ~last;
          if (last || pos == N) pos = 0;
          send(W'($urandom), W'($urandom), last);
        end
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        @(negedge clk);
        frame_ready = ($urandom_range(0, 3) != 0);
      end
    join

    frame_ready = 1'b1;
    idle(20);
    chk("end_pend_empty", N*W'(pend_q.size()), '0);
    chk("end_exp_empty",  N*W'(exp_q.size()), '0);
    chk("end_y_empty",    N*W'(yq.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
